riscv_dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data memory between two requesters: the pipelined core's MEM stage (cpu) and a debug/loader port (dbg).
- The debug port is used for array/result inspection and preloading by benches.
- The block sequences each access through a 3-state FSM and arbitrates contention round-robin.
- It generates the MEM-stage stall, and counts stall cycles for performance checks.

---
 rtl/riscv_dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_riscv_dmem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_arbiter.sv
// riscv_dmem_arbiter
// Shares one single-port synchronous data memory between the core's MEM stage
// (cpu) and a debug/loader port (dbg). Each access takes three cycles:
// IDLE (arbitrate and latch the request), ACCESS (drive memory), RESP (ack and
// return data). Contention is resolved round-robin, starting with the cpu
// after reset. The block also generates the MEM-stage stall and keeps a
// saturating count of stall cycles.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata         cpu request, held until cpu_ack
//   cpu_ack, cpu_rdata            one-cycle completion pulse, load data
//   cpu_stall                     cpu_req & ~cpu_ack
//   dbg_req/we/addr/wdata         debug request, held until dbg_ack
//   dbg_ack, dbg_rdata            one-cycle completion pulse, read data
//   mem_en/we/addr/wdata          memory command, driven in ACCESS only
//   mem_rdata                     memory read data, valid the cycle after mem_en
//   stall_cnt                     saturating count of cpu_stall cycles
module riscv_dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DBG = 1'b1;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              pick;

  // State register. Reset also kills an in-flight access: no ack is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_DBG;  // cpu wins the first contention
      win_q        <= GNT_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Next-state and datapath latching.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    pick         = GNT_CPU;
    // With both requesting, the one not served last wins.
    if (cpu_req && dbg_req) pick = ~last_grant_q;
    else if (dbg_req)       pick = GNT_DBG;
    case (state_q)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          win_d        = pick;
          last_grant_d = pick;
          we_d         = (pick == GNT_DBG) ? dbg_we    : cpu_we;
          addr_d       = (pick == GNT_DBG) ? dbg_addr  : cpu_addr;
          wdata_d      = (pick == GNT_DBG) ? dbg_wdata : cpu_wdata;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_RESP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    mem_en    = (state_q == S_ACCESS);
    mem_we    = mem_en && we_q;
    cpu_ack   = (state_q == S_RESP) && (win_q == GNT_CPU);
    dbg_ack   = (state_q == S_RESP) && (win_q == GNT_DBG);
    cpu_rdata = cpu_ack ? mem_rdata : cpu_rdata_q;
    dbg_rdata = dbg_ack ? mem_rdata : dbg_rdata_q;
    cpu_stall = cpu_req && !cpu_ack;
  end

  // Writes capture mem_rdata too; the value is meaningless but held.
  assign cpu_rdata_d = cpu_rdata;
  assign dbg_rdata_d = dbg_rdata;
  assign stall_cnt_d = (cpu_stall && (stall_cnt_q != {CNT_W{1'b1}}))
                       ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  // Memory command comes from the latched copy, never the live inputs.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
module tb_riscv_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ack, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] stall_cnt;

  // Second instance with a 4-bit counter for the saturation check.
  logic        s_req = 1'b0;
  logic        s_ack, s_stall, s_dack, s_men, s_mwe;
  logic [31:0] s_rdata, s_drdata, s_maddr, s_mwdata;
  logic [31:0] s_zero = '0;
  logic [3:0]  s_cnt;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mem [64];

  always #5 clk = ~clk;

  riscv_dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  riscv_dmem_arbiter #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .cpu_req(s_req), .cpu_we(1'b0), .cpu_addr(s_zero), .cpu_wdata(s_zero),
    .cpu_ack(s_ack), .cpu_rdata(s_rdata), .cpu_stall(s_stall),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(s_zero), .dbg_wdata(s_zero),
    .dbg_ack(s_dack), .dbg_rdata(s_drdata),
    .mem_en(s_men), .mem_we(s_mwe), .mem_addr(s_maddr), .mem_wdata(s_mwdata),
    .mem_rdata(s_zero), .stall_cnt(s_cnt)
  );

  // Synchronous single-port memory model, word-indexed.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Reset state
    rst = 1'b1;
    step();
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    rst = 1'b0;

    // cpu store 0xA to 0x10
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hA;
    #1;
    chk("st_n_stall", {31'd0, cpu_stall}, 32'd1);
    chk("st_n_mem_en", {31'd0, mem_en}, 32'd0);
    step();
    chk("st_n1_mem_en", {31'd0, mem_en}, 32'd1);
    chk("st_n1_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_n1_addr", mem_addr, 32'h10);
    chk("st_n1_wdata", mem_wdata, 32'hA);
    chk("st_n1_ack", {31'd0, cpu_ack}, 32'd0);
    step();
    chk("st_n2_ack", {31'd0, cpu_ack}, 32'd1);
    chk("st_n2_stall", {31'd0, cpu_stall}, 32'd0);
    chk("st_n2_mem_en", {31'd0, mem_en}, 32'd0);
    chk("st_n2_cnt", stall_cnt, 32'd2);
    cpu_req = 1'b0;
    step();
    chk("st_n3_ack", {31'd0, cpu_ack}, 32'd0);
    chk("st_n3_cnt", stall_cnt, 32'd2);

    // cpu load from 0x10
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
    step();
    chk("ld_n1_mem_en", {31'd0, mem_en}, 32'd1);
    chk("ld_n1_mem_we", {31'd0, mem_we}, 32'd0);
    step();
    chk("ld_n2_ack", {31'd0, cpu_ack}, 32'd1);
    chk("ld_n2_rdata", cpu_rdata, 32'hA);
    chk("ld_n2_dbg_ack", {31'd0, dbg_ack}, 32'd0);
    cpu_req = 1'b0;
    step();
    chk("ld_hold_rdata", cpu_rdata, 32'hA);
    chk("ld_cnt", stall_cnt, 32'd4);

    // First contention after reset: cpu reads 0x10, dbg writes 0x55 to 0x20
    rst = 1'b1;
    step();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h55;
    #1;
    chk("ct_n_stall", {31'd0, cpu_stall}, 32'd1);
    step();
    chk("ct_n1_stall", {31'd0, cpu_stall}, 32'd1);
    chk("ct_n1_addr", mem_addr, 32'h10);
    step();
    chk("ct_n2_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    chk("ct_n2_dbg_ack", {31'd0, dbg_ack}, 32'd0);
    chk("ct_n2_stall", {31'd0, cpu_stall}, 32'd0);
    chk("ct_n2_cnt", stall_cnt, 32'd2);
    cpu_req = 1'b0;
    step();
    chk("ct_n3_mem_en", {31'd0, mem_en}, 32'd0);
    step();
    chk("ct_n4_mem_en", {31'd0, mem_en}, 32'd1);
    chk("ct_n4_mem_we", {31'd0, mem_we}, 32'd1);
    chk("ct_n4_addr", mem_addr, 32'h20);
    chk("ct_n4_wdata", mem_wdata, 32'h55);
    chk("ct_n4_dbg_ack", {31'd0, dbg_ack}, 32'd0);
    step();
    chk("ct_n5_dbg_ack", {31'd0, dbg_ack}, 32'd1);
    dbg_req = 1'b0;
    step();

    // Continuous contention: expect cpu, dbg, cpu, dbg acks at +2, +5, +8, +11
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
    for (int c = 1; c <= 11; c++) begin
      step();
      chk($sformatf("rr_cpu_ack_c%0d", c), {31'd0, cpu_ack},
          {31'd0, (c == 2 || c == 8)});
      chk($sformatf("rr_dbg_ack_c%0d", c), {31'd0, dbg_ack},
          {31'd0, (c == 5 || c == 11)});
    end
    chk("rr_dbg_rdata", dbg_rdata, 32'h55);
    cpu_req = 1'b0; dbg_req = 1'b0;
    step();

    // Reset during ACCESS of a dbg write, then re-issue
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h30; dbg_wdata = 32'h77;
    step();
    chk("ra_access", {31'd0, mem_en}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ra_no_ack", {31'd0, dbg_ack}, 32'd0);
    chk("ra_mem_en", {31'd0, mem_en}, 32'd0);
    chk("ra_cnt", stall_cnt, 32'd0);
    step();
    chk("ra_re_mem_en", {31'd0, mem_en}, 32'd1);
    chk("ra_re_addr", mem_addr, 32'h30);
    step();
    chk("ra_re_ack", {31'd0, dbg_ack}, 32'd1);
    dbg_req = 1'b0;
    step();

    // Address changed mid-transaction: latched copy is used
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    step();
    cpu_addr = 32'h24;
    #1;
    chk("mid_addr", mem_addr, 32'h20);
    step();
    chk("mid_ack", {31'd0, cpu_ack}, 32'd1);
    chk("mid_rdata", cpu_rdata, 32'h55);
    cpu_req = 1'b0;
    step();

    // Saturation with a 4-bit counter: stall on 2 of every 3 cycles
    s_req = 1'b1;
    for (int i = 0; i < 21; i++) step();
    chk("sat_cnt_14", {28'd0, s_cnt}, 32'd14);
    for (int i = 0; i < 19; i++) step();
    chk("sat_cnt_f", {28'd0, s_cnt}, 32'hF);
    s_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
